// File: rtl/dac_output_serializer.sv
// Buffers packed multi-sample words in a small FIFO and streams one sample per
// clock toward the DAC, holding a midscale idle code whenever not streaming.
module dac_output_serializer #(
  parameter int                   SAMPLE_W    = 12,
  parameter int                   SAMPLES     = 8,
  parameter int                   FIFO_DEPTH  = 4,
  parameter int                   PRIME_LEVEL = 2,
  parameter logic [SAMPLE_W-1:0]  IDLE_CODE   = 12'h800
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  enable,
  input  logic [SAMPLE_W*SAMPLES-1:0]           s_data,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  output logic [SAMPLE_W-1:0]                   dac_data,
  output logic                                  dac_valid,
  output logic                                  frame_start,
  output logic                                  underflow,
  output logic [15:0]                           underflow_cnt,
  output logic [$clog2(FIFO_DEPTH):0]           fifo_level
);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int IW     = $clog2(SAMPLES);
  localparam int WORD_W = SAMPLE_W * SAMPLES;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRIME = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  logic [1:0]        state;
  logic [IW-1:0]     idx;
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [WORD_W-1:0] cur_word;
  logic [AW:0]       wr_ptr, rd_ptr, level, level_nxt;
  logic              push, pop, last;

  // Pointers carry one extra bit so full and empty differ; level wraps naturally.
  assign level      = wr_ptr - rd_ptr;
  assign fifo_level = level;
  assign push       = s_valid & s_ready;
  assign last       = (idx == IW'(SAMPLES - 1));

  always_comb begin
    pop = 1'b0;
    case (state)
      S_PRIME: pop = enable && (level >= (AW+1)'(PRIME_LEVEL));
      S_RUN:   pop = last && enable && (level != '0);
      default: pop = 1'b0;
    endcase
  end

  assign level_nxt = level + (AW+1)'(push) - (AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      idx           <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      cur_word      <= '0;
      s_ready       <= 1'b0;
      dac_data      <= IDLE_CODE;
      dac_valid     <= 1'b0;
      frame_start   <= 1'b0;
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        cur_word <= mem[rd_ptr[AW-1:0]];
      end
      // Ready looks at next-cycle occupancy so it never depends on s_valid combinationally.
      s_ready     <= (level_nxt < (AW+1)'(FIFO_DEPTH));
      dac_data    <= IDLE_CODE;
      dac_valid   <= 1'b0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
      case (state)
        S_IDLE: if (enable) state <= S_PRIME;
        S_PRIME: begin
          if (!enable) state <= S_IDLE;
          else if (pop) begin
            idx   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          dac_data    <= cur_word[idx*SAMPLE_W +: SAMPLE_W];
          dac_valid   <= 1'b1;
          frame_start <= (idx == '0);
          idx         <= idx + 1'b1;
          if (last) begin
            idx <= '0;
            if (!enable) state <= S_IDLE;
            else if (!pop) begin
              underflow <= 1'b1;
              if (underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 1'b1;
              state <= S_PRIME;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dac_output_serializer.sv
// Directed bench for dac_output_serializer: priming, gap-free streaming, underflow,
// backpressure, enable drop mid-word, reset mid-stream and counter saturation.
module tb_dac_output_serializer;
  logic        clk = 1'b0;
  logic        rst, enable, s_valid, s_ready;
  logic [95:0] s_data;
  logic [11:0] dac_data;
  logic        dac_valid, frame_start, underflow;
  logic [15:0] underflow_cnt;
  logic [2:0]  fifo_level;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  dac_output_serializer dut (
    .clk(clk), .rst(rst), .enable(enable), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .dac_data(dac_data), .dac_valid(dac_valid),
    .frame_start(frame_start), .underflow(underflow),
    .underflow_cnt(underflow_cnt), .fifo_level(fifo_level)
  );

  function automatic logic [95:0] mk(input logic [11:0] base);
    logic [95:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) w[12*k +: 12] = base + 12'(k);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [95:0] w);
    int   n;
    logic acc;
    n = 0; acc = 1'b0;
    s_data = w; s_valid = 1'b1;
    while (!acc && n < 20) begin
      acc = s_ready;
      @(negedge clk);
      n++;
    end
    s_valid = 1'b0;
    chk("push_accept", 32'(acc), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!dac_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(dac_valid), 32'd1);
  endtask

  task automatic wait_underflow(input string tag);
    int n;
    n = 0;
    while (!underflow && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(underflow), 32'd1);
  endtask

  // Checks samples from..to of a word, ending on the cycle that shows sample 'to'.
  task automatic check_word(input logic [11:0] base, input int from, input int to);
    for (int k = from; k <= to; k++) begin
      chk("sample_data", 32'(dac_data), 32'(base) + 32'(k));
      chk("sample_valid", 32'(dac_valid), 32'd1);
      chk("frame_start", 32'(frame_start), (k == 0) ? 32'd1 : 32'd0);
      if (k != to) @(negedge clk);
    end
  endtask

  initial begin
    int  n;
    logic seen;
    rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_dac_data", 32'(dac_data), 32'h800);
    chk("rst_dac_valid", 32'(dac_valid), 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_ucnt", 32'(underflow_cnt), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(s_ready), 32'd1);

    // Two words, gap-free stream, then underflow on the last sample.
    enable = 1'b1;
    push(mk(12'h000));
    push(mk(12'h010));
    wait_valid("stream_start");
    check_word(12'h000, 0, 7);
    chk("no_uf_at_boundary", 32'(underflow), 32'd0);
    @(negedge clk);
    check_word(12'h010, 0, 7);
    chk("uf_pulse", 32'(underflow), 32'd1);
    @(negedge clk);
    chk("uf_idle_valid", 32'(dac_valid), 32'd0);
    chk("uf_idle_data", 32'(dac_data), 32'h800);
    chk("uf_single_pulse", 32'(underflow), 32'd0);
    chk("uf_cnt_1", 32'(underflow_cnt), 32'd1);
    chk("uf_level", 32'(fifo_level), 32'd0);

    // One word below the priming level must not restart the stream.
    push(mk(12'h020));
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (dac_valid) seen = 1'b1;
    end
    chk("no_restart", 32'(seen), 32'd0);
    chk("level_1", 32'(fifo_level), 32'd1);

    // Fill to full while disabled; the fifth word is held off.
    enable = 1'b0;
    push(mk(12'h030));
    push(mk(12'h040));
    push(mk(12'h050));
    chk("full_ready", 32'(s_ready), 32'd0);
    chk("full_level", 32'(fifo_level), 32'd4);
    s_data = mk(12'h060); s_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("held_level", 32'(fifo_level), 32'd4);
    chk("held_ready", 32'(s_ready), 32'd0);
    enable = 1'b1;
    n = 0;
    while (!s_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("ready_reassert", 32'(s_ready), 32'd1);
    chk("level_after_pop", 32'(fifo_level), 32'd3);
    @(negedge clk);
    s_valid = 1'b0;
    chk("level_refill", 32'(fifo_level), 32'd4);

    // Drop enable at sample 3: the word completes, FIFO is untouched.
    check_word(12'h020, 0, 3);
    enable = 1'b0;
    @(negedge clk);
    check_word(12'h020, 4, 7);
    @(negedge clk);
    chk("stop_valid", 32'(dac_valid), 32'd0);
    chk("stop_data", 32'(dac_data), 32'h800);
    chk("stop_level", 32'(fifo_level), 32'd4);
    chk("stop_no_uf", 32'(underflow), 32'd0);

    // Reset while idx = 5 in RUN.
    enable = 1'b1;
    wait_valid("restart");
    check_word(12'h030, 0, 4);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_data", 32'(dac_data), 32'h800);
    chk("mrst_valid", 32'(dac_valid), 32'd0);
    chk("mrst_frame", 32'(frame_start), 32'd0);
    chk("mrst_level", 32'(fifo_level), 32'd0);
    chk("mrst_ucnt", 32'(underflow_cnt), 32'd0);
    chk("mrst_ready", 32'(s_ready), 32'd0);
    rst = 1'b0; enable = 1'b0;
    @(negedge clk);

    // Counter saturation from a preloaded value.
    force dut.underflow_cnt = 16'hFFFE;
    #1;
    release dut.underflow_cnt;
    enable = 1'b1;
    push(mk(12'h070));
    push(mk(12'h080));
    wait_underflow("sat_uf1");
    chk("sat_ffff", 32'(underflow_cnt), 32'hFFFF);
    push(mk(12'h090));
    push(mk(12'h0A0));
    @(negedge clk);
    wait_underflow("sat_uf2");
    chk("sat_hold", 32'(underflow_cnt), 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dac_output_serializer.md
Name: dac_output_serializer

Overview:
- Transmit-side counterpart of the ADC input path.
- Accepts 96-bit packed words (8 samples × 12 bits) through a valid/ready handshake and buffers them in a small FIFO.
- Emits one 12-bit sample per clock toward the DAC LVDS output buffers, with a frame marker on sample 0.
- Starts only after the FIFO is primed; on underflow, drops to a midscale idle code.

Parameters:
- SAMPLE_W, 12, bits per sample.
- SAMPLES, 8, samples per input word; input width = SAMPLE_W*SAMPLES.
- FIFO_DEPTH, 4, input word FIFO depth; power of two, ≥2.
- PRIME_LEVEL, 2, FIFO words required before streaming starts; 1..FIFO_DEPTH.
- IDLE_CODE, 12'h800, sample driven whenever not streaming (offset-binary midscale).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  streaming enable.
- s_data  in  96  packed word; sample k = s_data[12k+11:12k]; sample 0 is transmitted first.
- s_valid  in  1  s_data valid.
- s_ready  out  1  FIFO can accept a word.
- dac_data  out  12  registered sample to the DAC output buffers.
- dac_valid  out  1  dac_data carries a real sample.
- frame_start  out  1  high with sample 0 of each word.
- underflow  out  1  one-cycle pulse on underflow.
- underflow_cnt  out  16  saturating underflow count.
- fifo_level  out  3  words held in FIFO, 0..FIFO_DEPTH.

Behaviour:
- Reset values:
  - dac_data = IDLE_CODE; dac_valid, frame_start, underflow, s_ready = 0.
  - underflow_cnt = 0, fifo_level = 0, state = IDLE, idx = 0.
  - FIFO pointers cleared; held word content is don't-care.
- Reset mid-stream discards all buffered words with no partial output. Reset has priority over every other event.
- Handshake:
  - s_ready = (fifo_level < FIFO_DEPTH) and not in reset; registered from state, with no combinational path from s_valid.
  - A push occurs when s_valid & s_ready. A push and a pop in the same cycle are both honoured, and the level is unchanged.
- State machine:
  - IDLE: dac_data = IDLE_CODE, dac_valid = 0. If enable, go to PRIME.
  - PRIME: outputs as IDLE.
    - If !enable, go to IDLE.
    - Else if fifo_level ≥ PRIME_LEVEL: pop head into cur_word, set idx = 0, go to RUN.
  - RUN: each cycle drive dac_data ← cur_word[idx], dac_valid ← 1, frame_start ← (idx == 0), then idx ← idx+1.
  - When idx == SAMPLES-1 (word boundary), in priority order:
    - If !enable: go to IDLE; no pop.
    - Else if FIFO non-empty: pop into cur_word, idx ← 0, stay in RUN. The stream continues gap-free.
    - Else (underflow): pulse underflow for one cycle, underflow_cnt ← min(cnt+1, 16'hFFFF), go to PRIME.
- In the cycle after leaving RUN, dac_data = IDLE_CODE and dac_valid = 0.
- enable falling mid-word does not truncate the word. The current word completes; the FIFO contents are retained.
- Latency: push accepted into empty FIFO at edge N (PRIME_LEVEL = 1, state PRIME) → pop at edge N+1 → sample 0 on dac_data after edge N+2.
- A steady input rate of one word per 8 cycles sustains output indefinitely.
- Level arithmetic: pointers are log2(FIFO_DEPTH)+1 bits wide. The level is the pointer difference, and the pointers wrap naturally.

Test Plan:
- Reset, then enable=1, PRIME_LEVEL=2, push words W0 (samples 0x000..0x007) and W1 (0x010..0x017) → dac_data sequence 0x000..0x007,0x010..0x017.
  - Gap-free.
  - frame_start high on 0x000 and 0x010 only.
- After the above, no further pushes → underflow pulses once, underflow_cnt=1, dac_data=0x800, dac_valid=0, state PRIME; no stream restart with one word queued.
- Push 4 words with enable=0 → s_ready falls after 4th accept, fifo_level=4.
  - A 5th s_valid is held off.
  - Enable → ready reasserts after the first pop.
- Deassert enable at sample 3 of a word → samples 4..7 still emitted, then IDLE_CODE; remaining FIFO words retained (fifo_level unchanged).
- Assert rst while idx=5 in RUN → next cycle outputs at reset values, fifo_level=0, underflow_cnt=0.
- Force 0x10000 underflows (or preload the counter) → underflow_cnt saturates at 0xFFFF.
